reg_write_arbiter: RTL and testbench

- Round-robin arbiter that shares one WIDTH-bit holding register (a bank of D flip-flops) among N_REQ requesters.
- Each edge it either grants one requester a write or holds a locked owner for a burst.
- An owner that holds the lock too long is forcibly released after MAX_LOCK cycles.
- Sits between the requester logic and the shared register; q is the register output seen by downstream logic.

---
 rtl/reg_arb_pkg.sv | 23 ++
 rtl/rr_pick.sv | 27 ++
 rtl/reg_write_arbiter.sv | 105 ++++++++++
 tb/tb_reg_write_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// rtl/reg_arb_pkg.sv - shared types and helpers for the register write arbiter
package reg_arb_pkg;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int MAX_REQ = 32;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Callers truncate the result to their own requester count.
  function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
    return {{(MAX_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set req bit at or after ptr
module rr_pick #(
  parameter int N    = 4,
  parameter int IDXW = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic            found_o,
  output logic [IDXW-1:0] winner_o
);

  // Scanning from the far end lets the nearest candidate overwrite the others.
  always_comb begin
    found_o  = 1'b0;
    winner_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int idx;
      idx = int'(ptr_i) + k;
      if (idx >= N) idx = idx - N;
      if (req_i[idx]) begin
        found_o  = 1'b1;
        winner_o = IDXW'(idx);
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin arbiter sharing one holding register,
// with burst locking and forced release after MAX_LOCK cycles
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter  int N_REQ    = 4,
  parameter  int WIDTH    = 8,
  parameter  int MAX_LOCK = 4,
  localparam int IDXW     = clog2(N_REQ),
  localparam int CNTW     = clog2(MAX_LOCK + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       lock,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [IDXW-1:0]        owner,
  output logic [WIDTH-1:0]       q,
  output logic                   q_valid,
  output logic                   lock_abort
);

  arb_state_t       state_q;
  logic [IDXW-1:0]  ptr_q, ptr_d;
  logic [CNTW-1:0]  lock_cnt_q;
  logic [N_REQ-1:0] gnt_q;
  logic [IDXW-1:0]  owner_q;
  logic [WIDTH-1:0] q_q;
  logic             q_valid_q;
  logic             lock_abort_q;

  logic             pick_found;
  logic [IDXW-1:0]  pick_idx;

  rr_pick #(
    .N    (N_REQ),
    .IDXW (IDXW)
  ) u_rr_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .found_o  (pick_found),
    .winner_o (pick_idx)
  );

  assign ptr_d = (pick_idx == IDXW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB;
      ptr_q        <= '0;
      lock_cnt_q   <= '0;
      gnt_q        <= '0;
      owner_q      <= '0;
      q_q          <= '0;
      q_valid_q    <= 1'b0;
      lock_abort_q <= 1'b0;
    end else begin
      lock_abort_q <= 1'b0;
      case (state_q)
        ARB: begin
          if (!pick_found) begin
            gnt_q <= '0;
          end else begin
            q_q       <= wdata[pick_idx*WIDTH +: WIDTH];
            gnt_q     <= N_REQ'(onehot(int'(pick_idx)));
            owner_q   <= pick_idx;
            q_valid_q <= 1'b1;
            ptr_q     <= ptr_d;
            if (lock[pick_idx]) begin
              state_q    <= LOCKED;
              lock_cnt_q <= CNTW'(1);
            end
          end
        end
        LOCKED: begin
          // ptr_q already points past the owner, so release resumes fairly.
          if (lock_cnt_q == CNTW'(MAX_LOCK) && lock[owner_q]) begin
            gnt_q        <= '0;
            lock_abort_q <= 1'b1;
            lock_cnt_q   <= '0;
            state_q      <= ARB;
          end else if (req[owner_q]) begin
            q_q        <= wdata[owner_q*WIDTH +: WIDTH];
            gnt_q      <= N_REQ'(onehot(int'(owner_q)));
            lock_cnt_q <= lock_cnt_q + 1'b1;
            if (!lock[owner_q]) state_q <= ARB;
          end else begin
            gnt_q <= '0;
            if (!lock[owner_q]) state_q <= ARB;
            else lock_cnt_q <= lock_cnt_q + 1'b1;
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign gnt        = gnt_q;
  assign owner      = owner_q;
  assign q          = q_q;
  assign q_valid    = q_valid_q;
  assign lock_abort = lock_abort_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - directed and randomized checks of reg_write_arbiter
module tb_reg_write_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int ML = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req, lock;
  logic [N*W-1:0] wdata;
  logic [N-1:0] gnt;
  logic [1:0]   owner;
  logic [W-1:0] q;
  logic         q_valid, lock_abort;

  int tests_run = 0;
  int tests_failed = 0;

  reg_write_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_LOCK(ML)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .lock       (lock),
    .wdata      (wdata),
    .gnt        (gnt),
    .owner      (owner),
    .q          (q),
    .q_valid    (q_valid),
    .lock_abort (lock_abort)
  );

  always #5 clk = ~clk;

  // Reference model: who holds the register, and for how many cycles.
  logic [W-1:0] m_q;
  logic         m_valid, m_abort, m_locked;
  logic [N-1:0] m_gnt;
  int           m_owner, m_ptr, m_held;

  task automatic model_step();
    int w;
    bit found;
    if (rst) begin
      m_q = '0; m_valid = 0; m_gnt = '0; m_owner = 0; m_abort = 0;
      m_ptr = 0; m_held = 0; m_locked = 0;
      return;
    end
    m_abort = 0;
    if (!m_locked) begin
      found = 0; w = 0;
      for (int k = 0; k < N; k++)
        if (!found && req[(m_ptr + k) % N]) begin found = 1; w = (m_ptr + k) % N; end
      if (!found) m_gnt = '0;
      else begin
        m_q = wdata[w*W +: W]; m_gnt = N'(1) << w; m_owner = w; m_valid = 1;
        m_ptr = (w + 1) % N;
        if (lock[w]) begin m_locked = 1; m_held = 1; end
      end
    end else if (m_held == ML && lock[m_owner]) begin
      m_gnt = '0; m_abort = 1; m_locked = 0; m_held = 0;
    end else if (req[m_owner]) begin
      m_q = wdata[m_owner*W +: W]; m_gnt = N'(1) << m_owner; m_held++;
      if (!lock[m_owner]) m_locked = 0;
    end else begin
      m_gnt = '0;
      if (!lock[m_owner]) m_locked = 0; else m_held++;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; req = '0; lock = '0;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; req = '0; lock = '0; wdata = '0;
    tick(); tick();
    tests_run++;
    if ({q, q_valid, gnt, owner, lock_abort} !== '0) begin
      tests_failed++;
      $display("FAIL reset_idle: q=%h v=%b gnt=%b own=%0d ab=%b, want all zero", q, q_valid, gnt, owner, lock_abort);
    end
    req = 4'b1111; lock = 4'b1111; wdata = 32'hDEADBEEF;
    tick();
    tests_run++;
    if ({q, q_valid, gnt, owner, lock_abort} !== '0) begin
      tests_failed++;
      $display("FAIL reset_req: q=%h v=%b gnt=%b own=%0d ab=%b, want all zero", q, q_valid, gnt, owner, lock_abort);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    req = 4'b0001; lock = '0; wdata = '0; wdata[7:0] = 8'hA5;
    tick();
    tests_run++;
    if (gnt !== 4'b0001 || q !== 8'hA5 || owner !== 2'd0 || q_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_write: gnt=%b q=%h own=%0d v=%b, want 0001 a5 0 1", gnt, q, owner, q_valid);
    end
    req = '0;
    tick();
    tests_run++;
    if (gnt !== 4'b0000 || q !== 8'hA5) begin
      tests_failed++;
      $display("FAIL single_hold: gnt=%b q=%h, want 0000 a5", gnt, q);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] exp_q [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    do_reset();
    req = 4'b1111; lock = '0; wdata = 32'h44332211;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if (gnt !== exp_g[i] || q !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL fairness[%0d]: gnt=%b q=%h, want %b %h", i, gnt, q, exp_g[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_burst();
    logic [7:0] d [3] = '{8'h01, 8'h02, 8'h03};
    do_reset();
    req = 4'b0110; lock = 4'b0010; wdata = '0; wdata[23:16] = 8'hCC;
    for (int i = 0; i < 3; i++) begin
      wdata[15:8] = d[i];
      if (i == 2) lock = '0;
      tick();
      tests_run++;
      if (gnt !== 4'b0010 || q !== d[i]) begin
        tests_failed++;
        $display("FAIL burst[%0d]: gnt=%b q=%h, want 0010 %h", i, gnt, q, d[i]);
      end
    end
    req = 4'b0100;
    tick();
    tests_run++;
    if (gnt !== 4'b0100 || q !== 8'hCC) begin
      tests_failed++;
      $display("FAIL burst_next: gnt=%b q=%h, want 0100 cc", gnt, q);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req = 4'b1001; lock = 4'b0001; wdata = 32'h3C00005A;
    for (int i = 0; i < ML; i++) begin
      tick();
      tests_run++;
      if (gnt !== 4'b0001 || lock_abort !== 1'b0 || q !== 8'h5A) begin
        tests_failed++;
        $display("FAIL timeout_hold[%0d]: gnt=%b ab=%b q=%h, want 0001 0 5a", i, gnt, lock_abort, q);
      end
    end
    tick();
    tests_run++;
    if (gnt !== 4'b0000 || lock_abort !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_abort: gnt=%b ab=%b, want 0000 1", gnt, lock_abort);
    end
    tick();
    tests_run++;
    if (gnt !== 4'b1000 || lock_abort !== 1'b0 || q !== 8'h3C || owner !== 2'd3) begin
      tests_failed++;
      $display("FAIL timeout_release: gnt=%b ab=%b q=%h own=%0d, want 1000 0 3c 3", gnt, lock_abort, q, owner);
    end
  endtask

  task automatic test_reset_locked();
    do_reset();
    req = 4'b0001; lock = 4'b0001; wdata = 32'h00000077;
    tick();
    rst = 1;
    tick();
    tests_run++;
    if (q !== 8'h00 || gnt !== 4'b0000 || q_valid !== 1'b0 || owner !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_locked: q=%h gnt=%b v=%b own=%0d, want 00 0000 0 0", q, gnt, q_valid, owner);
    end
    rst = 0; req = 4'b0011; lock = '0; wdata = 32'h00002010;
    tick();
    tests_run++;
    if (gnt !== 4'b0001 || q !== 8'h10) begin
      tests_failed++;
      $display("FAIL reset_locked_after: gnt=%b q=%h, want 0001 10", gnt, q);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < N; i++) begin
        req[i]  = ($urandom_range(0, 9) < 6);
        lock[i] = ($urandom_range(0, 9) < 8);
      end
      wdata = $urandom;
      tick();
      tests_run++;
      if ({q, q_valid, gnt, owner, lock_abort} !== {m_q, m_valid, m_gnt, 2'(m_owner), m_abort}) begin
        tests_failed++;
        $display("FAIL random[%0d]: q=%h v=%b gnt=%b own=%0d ab=%b, want q=%h v=%b gnt=%b own=%0d ab=%b",
                 c, q, q_valid, gnt, owner, lock_abort, m_q, m_valid, m_gnt, m_owner, m_abort);
      end
    end
    rst = 0;
  endtask

  initial begin
    rst = 1; req = '0; lock = '0; wdata = '0;
    test_reset();
    test_single_write();
    test_fairness();
    test_burst();
    test_timeout();
    test_reset_locked();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
